spi_bus_arbiter: RTL and testbench

- Owns the single shared SPI bus: flash_cs_n, ram_cs_n, spi_sclk, spi_mosi and spi_miso.
- Serves two requesters:
  - the instruction-fetch port, which reads flash;
  - the data port, which reads and writes RAM.
- Arbitrates round-robin between the two ports.
- Sequences each granted transfer as command, 24-bit address, then data, using SPI mode 0.
- Sits between the memory controller's request logic and the SoC SPI pins.

---
 rtl/spi_bus_arbiter_if.sv | 34 +++
 rtl/spi_bus_arbiter.sv | 242 ++++++++++++++++++++++++
 tb/tb_spi_bus_arbiter.sv | 384 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_bus_arbiter_if.sv
// Request/response signals of the fetch and data ports plus the shared SPI pins.
// The arbiter connects through the slave modport; the requester/pin side uses master.
interface spi_bus_arbiter_if;
    logic        f_req;
    logic [23:0] f_addr;
    logic [31:0] f_rdata;
    logic        f_done;

    logic        d_req;
    logic        d_we;
    logic [23:0] d_addr;
    logic [31:0] d_wdata;
    logic [2:0]  d_nbytes;
    logic [31:0] d_rdata;
    logic        d_done;

    logic        flash_cs_n;
    logic        ram_cs_n;
    logic        spi_sclk;
    logic        spi_mosi;
    logic        spi_miso;

    modport master (
        output f_req, f_addr, d_req, d_we, d_addr, d_wdata, d_nbytes, spi_miso,
        input  f_rdata, f_done, d_rdata, d_done,
        input  flash_cs_n, ram_cs_n, spi_sclk, spi_mosi
    );

    modport slave (
        input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, d_nbytes, spi_miso,
        output f_rdata, f_done, d_rdata, d_done,
        output flash_cs_n, ram_cs_n, spi_sclk, spi_mosi
    );
endinterface

// File: rtl/spi_bus_arbiter.sv
// Round-robin owner of the shared SPI bus (flash fetch port, RAM data port), mode 0.
// Optional SPI_FAST_READ_EN: fetches use opcode 0x0B with 8 dummy bits after the address.
module spi_bus_arbiter #(
    parameter int unsigned CLK_DIV      = 1,
    parameter logic [7:0]  FLASH_RD_CMD = 8'h03,
    parameter logic [7:0]  RAM_RD_CMD   = 8'h03,
    parameter logic [7:0]  RAM_WR_CMD   = 8'h02
) (
    input  logic              clk,
    input  logic              rst_n,
    spi_bus_arbiter_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_DATA,
        ST_END
    } state_e;

    typedef enum logic {
        PORT_FETCH = 1'b0,
        PORT_DATA  = 1'b1
    } port_e;

    localparam logic [8:0] HALF_LAST = 9'(CLK_DIV - 1);
    localparam logic [8:0] END_LAST  = 9'(2 * CLK_DIV - 1);

`ifdef SPI_FAST_READ_EN
    localparam logic [7:0] FETCH_CMD = 8'h0B;
`else
    localparam logic [7:0] FETCH_CMD = FLASH_RD_CMD;
`endif

    state_e      state_q, state_d;
    port_e       port_q, port_d;
    port_e       last_q, last_d;
    logic        we_q, we_d;
    logic [2:0]  nbytes_q, nbytes_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [23:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rx_q, rx_d;
    logic [8:0]  div_q, div_d;
    logic [5:0]  bit_q, bit_d;
    logic        sclk_q, sclk_d;
    logic        mosi_q, mosi_d;
    logic        flash_cs_n_q, flash_cs_n_d;
    logic        ram_cs_n_q, ram_cs_n_d;
    logic        f_done_q, f_done_d;
    logic        d_done_q, d_done_d;
    logic [31:0] f_rdata_q, f_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;

    logic        grant_data;
    logic [5:0]  field_last;

    // Data bytes travel little-endian, each byte MSB first: wire bit i maps to word bit {i[4:3], ~i[2:0]}.
    function automatic logic tx_bit(state_e st, logic [5:0] idx, logic [7:0] cmd,
                                    logic [23:0] addr, logic [31:0] wdata, logic we);
        logic b;
        b = 1'b0;
        case (st)
            ST_CMD:  b = cmd[~idx[2:0]];
            ST_ADDR: b = addr[5'(6'd23 - idx)];
            ST_DATA: b = we & wdata[{idx[4:3], ~idx[2:0]}];
            default: b = 1'b0;
        endcase
        return b;
    endfunction

    always_comb begin
        case (state_q)
            ST_ADDR: field_last = 6'd23;
            ST_DATA: field_last = {nbytes_q, 3'b000} - 6'd1;
            default: field_last = 6'd7;
        endcase
    end

    always_comb begin
        // NOTE: every value written here gets a default first, so no path can infer a latch.
        state_d      = state_q;
        port_d       = port_q;
        last_d       = last_q;
        we_d         = we_q;
        nbytes_d     = nbytes_q;
        cmd_d        = cmd_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rx_d         = rx_q;
        div_d        = div_q;
        bit_d        = bit_q;
        sclk_d       = sclk_q;
        mosi_d       = mosi_q;
        flash_cs_n_d = flash_cs_n_q;
        ram_cs_n_d   = ram_cs_n_q;
        f_done_d     = 1'b0;
        d_done_d     = 1'b0;
        f_rdata_d    = f_rdata_q;
        d_rdata_d    = d_rdata_q;
        grant_data   = bus.d_req && (!bus.f_req || last_q == PORT_FETCH);

        case (state_q)
            ST_IDLE: begin
                if (bus.f_req || bus.d_req) begin
                    state_d      = ST_CMD;
                    port_d       = grant_data ? PORT_DATA : PORT_FETCH;
                    last_d       = port_d;
                    we_d         = grant_data && bus.d_we;
                    addr_d       = grant_data ? bus.d_addr : bus.f_addr;
                    wdata_d      = bus.d_wdata;
                    if (grant_data && (bus.d_nbytes == 3'd1 || bus.d_nbytes == 3'd2))
                        nbytes_d = bus.d_nbytes;
                    else
                        nbytes_d = 3'd4;
                    if (!grant_data)
                        cmd_d = FETCH_CMD;
                    else
                        cmd_d = bus.d_we ? RAM_WR_CMD : RAM_RD_CMD;
                    flash_cs_n_d = grant_data;
                    ram_cs_n_d   = !grant_data;
                    mosi_d       = cmd_d[7];
                    div_d        = '0;
                    bit_d        = '0;
                    sclk_d       = 1'b0;
                    rx_d         = '0;
                end
            end

            ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA: begin
                if (div_q != HALF_LAST) begin
                    div_d = div_q + 9'd1;
                end else begin
                    div_d  = '0;
                    sclk_d = !sclk_q;
                    if (!sclk_q) begin
                        if (state_q == ST_DATA && !we_q)
                            rx_d[{bit_q[4:3], ~bit_q[2:0]}] = bus.spi_miso;
                    end else if (bit_q != field_last) begin
                        bit_d  = bit_q + 6'd1;
                        mosi_d = tx_bit(state_q, bit_d, cmd_q, addr_q, wdata_q, we_q);
                    end else begin
                        bit_d = '0;
                        case (state_q)
                            ST_CMD:   state_d = ST_ADDR;
                            ST_ADDR: begin
`ifdef SPI_FAST_READ_EN
                                state_d = (port_q == PORT_FETCH) ? ST_DUMMY : ST_DATA;
`else
                                state_d = ST_DATA;
`endif
                            end
                            ST_DUMMY: state_d = ST_DATA;
                            default:  state_d = ST_END;
                        endcase
                        mosi_d = tx_bit(state_d, 6'd0, cmd_q, addr_q, wdata_q, we_q);
                        if (state_d == ST_END) begin
                            flash_cs_n_d = 1'b1;
                            ram_cs_n_d   = 1'b1;
                            if (port_q == PORT_FETCH) begin
                                f_done_d  = 1'b1;
                                f_rdata_d = rx_q;
                            end else begin
                                d_done_d  = 1'b1;
                                d_rdata_d = we_q ? 32'd0 : rx_q;
                            end
                        end
                    end
                end
            end

            ST_END: begin
                // Both selects stay high here for the chip deselect time before the next grant.
                if (div_q != END_LAST) begin
                    div_d = div_q + 9'd1;
                end else begin
                    div_d   = '0;
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            port_q       <= PORT_FETCH;
            last_q       <= PORT_DATA;
            we_q         <= 1'b0;
            nbytes_q     <= 3'd4;
            cmd_q        <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rx_q         <= '0;
            div_q        <= '0;
            bit_q        <= '0;
            sclk_q       <= 1'b0;
            mosi_q       <= 1'b0;
            flash_cs_n_q <= 1'b1;
            ram_cs_n_q   <= 1'b1;
            f_done_q     <= 1'b0;
            d_done_q     <= 1'b0;
            f_rdata_q    <= '0;
            d_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            port_q       <= port_d;
            last_q       <= last_d;
            we_q         <= we_d;
            nbytes_q     <= nbytes_d;
            cmd_q        <= cmd_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rx_q         <= rx_d;
            div_q        <= div_d;
            bit_q        <= bit_d;
            sclk_q       <= sclk_d;
            mosi_q       <= mosi_d;
            flash_cs_n_q <= flash_cs_n_d;
            ram_cs_n_q   <= ram_cs_n_d;
            f_done_q     <= f_done_d;
            d_done_q     <= d_done_d;
            f_rdata_q    <= f_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    assign bus.flash_cs_n = flash_cs_n_q;
    assign bus.ram_cs_n   = ram_cs_n_q;
    assign bus.spi_sclk   = sclk_q;
    assign bus.spi_mosi   = mosi_q;
    assign bus.f_done     = f_done_q;
    assign bus.d_done     = d_done_q;
    assign bus.f_rdata    = f_rdata_q;
    assign bus.d_rdata    = d_rdata_q;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Scoreboard bench for spi_bus_arbiter: drivers push expected transfers, a negedge
// process models the flash/RAM slaves and checks every grant and completion.
module tb_spi_bus_arbiter;

    localparam int CLK_DIV = 1;
    localparam int TIMEOUT = 2000;
`ifdef SPI_FAST_READ_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] rdata;
        logic [71:0] wire_bits;
        logic [6:0]  nbits;
    } exp_t;

    typedef struct packed {
        logic        we;
        logic [2:0]  nb;
        logic [23:0] addr;
        logic [31:0] wdata;
    } dreq_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_bus_arbiter_if bus ();

    spi_bus_arbiter #(.CLK_DIV(CLK_DIV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

    exp_t        exp_f[$];
    exp_t        exp_d[$];
    logic        exp_grant[$];
    logic [23:0] f_stim[$];
    dreq_t       d_stim[$];
    logic        model_last;

    logic [7:0] flash_mem [int unsigned];
    logic [7:0] slave_ram [int unsigned];
    logic [7:0] ref_ram   [int unsigned];

    task automatic check(input string name, input logic [71:0] got, input logic [71:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] init_byte(logic [23:0] a, logic [7:0] salt);
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ salt;
    endfunction

    function automatic logic [7:0] flash_rd(logic [23:0] a);
        if (flash_mem.exists(a)) return flash_mem[a];
        return init_byte(a, 8'hC3);
    endfunction

    function automatic logic [7:0] slave_ram_rd(logic [23:0] a);
        if (slave_ram.exists(a)) return slave_ram[a];
        return init_byte(a, 8'h5A);
    endfunction

    function automatic logic [7:0] ref_ram_rd(logic [23:0] a);
        if (ref_ram.exists(a)) return ref_ram[a];
        return init_byte(a, 8'h5A);
    endfunction

    // Reference: wire image (cmd, addr, optional dummy, data) and the rdata the port should report.
    function automatic exp_t make_exp(logic is_data, logic we, logic [2:0] nb,
                                      logic [23:0] addr, logic [31:0] wdata);
        exp_t        e;
        int          n;
        logic [7:0]  cmd;
        logic [7:0]  b;
        logic [23:0] a;
        e = '0;
        n = !is_data ? 4 : (nb == 3'd1) ? 1 : (nb == 3'd2) ? 2 : 4;
        if (!is_data) cmd = FAST ? 8'h0B : 8'h03;
        else          cmd = we ? 8'h02 : 8'h03;
        for (int i = 7; i >= 0; i--) begin
            e.wire_bits = {e.wire_bits[70:0], cmd[i]};
            e.nbits++;
        end
        for (int i = 23; i >= 0; i--) begin
            e.wire_bits = {e.wire_bits[70:0], addr[i]};
            e.nbits++;
        end
        if (FAST && !is_data) begin
            e.wire_bits = e.wire_bits << 8;
            e.nbits += 7'd8;
        end
        for (int k = 0; k < n; k++) begin
            a = 24'(addr + 24'(k));
            if (is_data && we) begin
                b = wdata[8*k +: 8];
                ref_ram[a] = b;
            end else begin
                b = 8'h00;
                e.rdata[8*k +: 8] = is_data ? ref_ram_rd(a) : flash_rd(a);
            end
            for (int i = 7; i >= 0; i--) begin
                e.wire_bits = {e.wire_bits[70:0], b[i]};
                e.nbits++;
            end
        end
        return e;
    endfunction

    task automatic push_grant(input logic is_data);
        exp_grant.push_back(is_data);
        model_last = is_data;
    endtask

    task automatic drive_fetch();
        logic [23:0] a;
        int          t;
        while (f_stim.size() > 0) begin
            a = f_stim.pop_front();
            exp_f.push_back(make_exp(1'b0, 1'b0, 3'd4, a, 32'd0));
            bus.f_addr = a;
            bus.f_req  = 1'b1;
            t = 0;
            do begin @(negedge clk); t++; end while (!bus.f_done && t < TIMEOUT);
            check("f_done before timeout", {71'd0, bus.f_done}, 72'd1);
        end
        bus.f_req = 1'b0;
    endtask

    task automatic drive_data();
        dreq_t r;
        int    t;
        while (d_stim.size() > 0) begin
            r = d_stim.pop_front();
            exp_d.push_back(make_exp(1'b1, r.we, r.nb, r.addr, r.wdata));
            bus.d_we     = r.we;
            bus.d_nbytes = r.nb;
            bus.d_addr   = r.addr;
            bus.d_wdata  = r.wdata;
            bus.d_req    = 1'b1;
            t = 0;
            do begin @(negedge clk); t++; end while (!bus.d_done && t < TIMEOUT);
            check("d_done before timeout", {71'd0, bus.d_done}, 72'd1);
        end
        bus.d_req = 1'b0;
    endtask

    // Slave model and monitor state
    int          cyc = 0;
    int          grant_cyc = 0;
    int          gap = 1000;
    int          cnt = 0;
    int          last_cnt = 0;
    logic [71:0] cap = '0;
    logic [71:0] last_cap = '0;
    logic        cs_prev = 1'b0;
    logic        sclk_prev = 1'b0;
    logic        overlap = 1'b0;
    logic        slave_is_flash = 1'b0;
    logic [7:0]  slave_cmd = '0;
    logic [23:0] slave_addr = '0;
    logic        prev_f_done = 1'b0;
    logic        prev_d_done = 1'b0;

    task automatic check_done(input logic is_data);
        exp_t        e;
        logic [31:0] got;
        got = is_data ? bus.d_rdata : bus.f_rdata;
        if (is_data) begin
            check("d_done has pending request", {71'd0, exp_d.size() != 0}, 72'd1);
            if (exp_d.size() == 0) return;
            e = exp_d.pop_front();
            check("d_done one cycle", {71'd0, prev_d_done}, 72'd0);
            check("d_rdata", {40'd0, got}, {40'd0, e.rdata});
        end else begin
            check("f_done has pending request", {71'd0, exp_f.size() != 0}, 72'd1);
            if (exp_f.size() == 0) return;
            e = exp_f.pop_front();
            check("f_done one cycle", {71'd0, prev_f_done}, 72'd0);
            check("f_rdata", {40'd0, got}, {40'd0, e.rdata});
        end
        check("wire bit count", 72'(last_cnt), 72'(e.nbits));
        check("wire bits", last_cap, e.wire_bits);
        check("grant-to-done latency", 72'(cyc - grant_cyc), 72'(2 * CLK_DIV * int'(e.nbits)));
        check("chip selects never overlap", {71'd0, overlap}, 72'd0);
    endtask

    always @(negedge clk) begin
        logic        cs_act;
        int          ds;
        int          db;
        logic [7:0]  b;
        cyc++;
        cs_act = !bus.flash_cs_n || !bus.ram_cs_n;
        if (!bus.flash_cs_n && !bus.ram_cs_n) overlap = 1'b1;

        if (cs_act && !cs_prev) begin
            check("grant has pending request", {71'd0, exp_grant.size() != 0}, 72'd1);
            if (exp_grant.size() != 0)
                check("grant port (1=data)", {71'd0, !bus.ram_cs_n}, {71'd0, exp_grant.pop_front()});
            check("cs deselect gap", {71'd0, gap >= 2 * CLK_DIV}, 72'd1);
            grant_cyc      = cyc;
            cnt            = 0;
            cap            = '0;
            slave_is_flash = !bus.flash_cs_n;
        end

        if (cs_act) begin
            gap = 0;
            if (bus.spi_sclk && !sclk_prev) begin
                cap = {cap[70:0], bus.spi_mosi};
                cnt++;
                if (cnt == 32) begin
                    slave_cmd  = cap[31:24];
                    slave_addr = cap[23:0];
                end
            end
            ds = (slave_is_flash && FAST) ? 40 : 32;
            if (!bus.spi_sclk) begin
                if (cnt >= ds) begin
                    b = slave_is_flash ? flash_rd(24'(slave_addr + 24'((cnt - ds) / 8)))
                                       : slave_ram_rd(24'(slave_addr + 24'((cnt - ds) / 8)));
                    bus.spi_miso = b[7 - ((cnt - ds) % 8)];
                end else begin
                    bus.spi_miso = 1'b0;
                end
            end
        end else begin
            if (cs_prev) begin
                last_cap = cap;
                last_cnt = cnt;
                if (!slave_is_flash && slave_cmd == 8'h02 && cnt > 32) begin
                    db = cnt - 32;
                    for (int k = 0; k < db / 8; k++)
                        slave_ram[24'(slave_addr + 24'(k))] = cap[db - 1 - 8 * k -: 8];
                end
            end
            gap++;
            bus.spi_miso = 1'b0;
        end

        if (bus.f_done === 1'b1) check_done(1'b0);
        if (bus.d_done === 1'b1) check_done(1'b1);

        prev_f_done = bus.f_done;
        prev_d_done = bus.d_done;
        sclk_prev   = bus.spi_sclk;
        cs_prev     = cs_act;
    end

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_last = 1'b1;
    endtask

    task automatic random_round(input bit use_f, input bit use_d, input int k);
        dreq_t r;
        for (int i = 0; i < k; i++) begin
            if (use_f && use_d) begin
                push_grant(!model_last);
                push_grant(!model_last);
            end else begin
                push_grant(use_d);
            end
            if (use_f) f_stim.push_back(24'($urandom));
            if (use_d) begin
                r.we    = 1'($urandom);
                r.nb    = 3'($urandom_range(0, 7));
                r.addr  = 24'($urandom_range(0, 63));
                r.wdata = $urandom;
                d_stim.push_back(r);
            end
        end
        fork
            drive_fetch();
            drive_data();
        join
    endtask

    initial begin
        dreq_t r;
        int    t;
        bus.f_req    = 1'b0;
        bus.f_addr   = '0;
        bus.d_req    = 1'b0;
        bus.d_we     = 1'b0;
        bus.d_addr   = '0;
        bus.d_wdata  = '0;
        bus.d_nbytes = 3'd4;
        bus.spi_miso = 1'b0;
        model_last   = 1'b1;

        do_reset();
        check("reset cs/sclk/mosi/done",
              {66'd0, bus.flash_cs_n, bus.ram_cs_n, bus.spi_sclk, bus.spi_mosi, bus.f_done, bus.d_done},
              {66'd0, 6'b110000});
        check("reset f_rdata", {40'd0, bus.f_rdata}, 72'd0);
        check("reset d_rdata", {40'd0, bus.d_rdata}, 72'd0);

        // Fetch at 0x000100 with flash bytes 13,00,00,00
        flash_mem[24'h000100] = 8'h13;
        flash_mem[24'h000101] = 8'h00;
        flash_mem[24'h000102] = 8'h00;
        flash_mem[24'h000103] = 8'h00;
        push_grant(1'b0);
        f_stim.push_back(24'h000100);
        drive_fetch();

        // One-byte write of A5 to 0x000010
        push_grant(1'b1);
        r.we = 1'b1; r.nb = 3'd1; r.addr = 24'h000010; r.wdata = 32'hDEADBEA5;
        d_stim.push_back(r);
        drive_data();

        // Two-byte read of 34,12 from 0x000020
        slave_ram[24'h000020] = 8'h34;
        slave_ram[24'h000021] = 8'h12;
        ref_ram[24'h000020]   = 8'h34;
        ref_ram[24'h000021]   = 8'h12;
        push_grant(1'b1);
        r.we = 1'b0; r.nb = 3'd2; r.addr = 24'h000020; r.wdata = 32'h0;
        d_stim.push_back(r);
        drive_data();

        // Both ports together right after reset: fetch first, then alternating
        do_reset();
        random_round(1'b1, 1'b1, 3);

        // Reset while the address is being shifted
        push_grant(1'b0);
        bus.f_addr = 24'h123456;
        bus.f_req  = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (bus.flash_cs_n && t < TIMEOUT);
        check("flash selected before mid-transfer reset", {71'd0, bus.flash_cs_n}, 72'd0);
        repeat (16 * CLK_DIV + 10) @(negedge clk);
        rst_n     = 1'b0;
        bus.f_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_last = 1'b1;
        check("after mid-transfer reset cs/sclk/done",
              {67'd0, bus.flash_cs_n, bus.ram_cs_n, bus.spi_sclk, bus.f_done, bus.d_done},
              {67'd0, 5'b11000});
        check("after mid-transfer reset f_rdata", {40'd0, bus.f_rdata}, 72'd0);
        repeat (20) @(negedge clk);
        push_grant(1'b0);
        f_stim.push_back(24'h00ABCD);
        drive_fetch();

        // Randomised traffic
        for (int i = 0; i < 6; i++) begin
            case ($urandom_range(0, 2))
                0:       random_round(1'b1, 1'b0, int'($urandom_range(1, 2)));
                1:       random_round(1'b0, 1'b1, int'($urandom_range(1, 3)));
                default: random_round(1'b1, 1'b1, int'($urandom_range(1, 3)));
            endcase
        end

        repeat (10) @(negedge clk);
        check("no leftover expectations", 72'(exp_f.size() + exp_d.size() + exp_grant.size()), 72'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
